imem_load_ctrl: RTL and testbench

- Host-side programming controller for the 512x32 instruction memory and its fetch stage.
- Accepts a load session (base address, length), streams 32-bit words from the host over a valid/ready handshake, and drives the imem host-write port (write_to_imem, addr_imem_host, imem_data) with auto-incrementing addresses.
- Holds the core in reset while loading, then applies a flush period and releases the core to run.
- Sits between the host interface and the fetch stage; sole owner of write_to_imem.

---
 rtl/imem_load_ctrl.sv | 138 +++++++++++++
 tb/tb_imem_load_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// Host-side loader for the instruction memory. It streams words from the host
// into imem, holds the core in reset while loading, flushes, then releases the core.
//
// state | meaning
// IDLE  | core held in reset, waiting for host_start
// LOAD  | accepting host words, one imem write per handshake
// FLUSH | last word written, core still in reset for FLUSH_CYCLES cycles
// RUN   | core released and executing until host_halt
module imem_load_ctrl #(
  parameter int AW           = 9,
  parameter int DW           = 32,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_start,
  input  logic [AW-1:0] host_base_addr,
  input  logic [AW:0]   host_len,
  input  logic          host_abort,
  input  logic          host_halt,
  input  logic          host_valid,
  input  logic [DW-1:0] host_data,
  output logic          host_ready,
  output logic          write_to_imem,
  output logic [AW-1:0] addr_imem_host,
  output logic [DW-1:0] imem_data,
  output logic          core_rst,
  output logic          run,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   words_written
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  localparam int            MEM_WORDS_I = 1 << AW;
  localparam logic [AW+1:0] MEM_WORDS   = (AW+2)'(MEM_WORDS_I);
  localparam logic [3:0]    FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [3:0]    flush_cnt;
  logic [AW+1:0] end_addr;
  logic          range_bad;
  logic          start_ok;
  logic          hs;
  logic          last_hs;

  // The range check runs one bit wider than the length so base+len never overflows.
  assign end_addr   = {2'b00, host_base_addr} + {1'b0, host_len};
  assign range_bad  = (host_len == '0) || (end_addr > MEM_WORDS);
  assign start_ok   = (state == IDLE) && host_start && !range_bad;
  assign host_ready = (state == LOAD);
  // Abort takes priority: a handshake coinciding with it is dropped.
  assign hs         = host_ready && host_valid && !host_abort;
  // words_written equals the index of the handshake in progress.
  assign last_hs    = hs && ((words_written + (AW+1)'(1)) == len_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = LOAD;
      LOAD: begin
        if (host_abort)   state_nxt = IDLE;
        else if (last_hs) state_nxt = FLUSH;
      end
      FLUSH:   if (flush_cnt == '0) state_nxt = RUN;
      RUN:     if (host_halt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered status outputs track the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst <= 1'b1;
      run      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      core_rst <= (state_nxt != RUN);
      run      <= (state_nxt == RUN);
      busy     <= (state_nxt == LOAD) || (state_nxt == FLUSH);
      done     <= (state_nxt == RUN) && (state != RUN);
    end
  end

  // Session capture, error flag and flush down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      len_q     <= '0;
      err       <= 1'b0;
      flush_cnt <= '0;
    end else begin
      if ((state == IDLE) && host_start) begin
        base_q <= host_base_addr;
        len_q  <= host_len;
        err    <= range_bad;
      end else if ((state == LOAD) && host_abort) begin
        err <= 1'b1;
      end
      if (last_hs)
        flush_cnt <= FLUSH_LOAD;
      else if ((state == FLUSH) && (flush_cnt != '0))
        flush_cnt <= flush_cnt - 4'd1;
    end
  end

  // imem write port: one registered write the cycle after each handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_to_imem  <= 1'b0;
      addr_imem_host <= '0;
      imem_data      <= '0;
      words_written  <= '0;
    end else begin
      write_to_imem <= hs;
      if ((state == IDLE) && host_start) begin
        words_written <= '0;
      end else if (hs) begin
        addr_imem_host <= base_q + words_written[AW-1:0];
        imem_data      <= host_data;
        words_written  <= words_written + (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: load, backpressure, range error, abort,
// halt/reload and asynchronous reset during a load.
module tb_imem_load_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_start = 1'b0;
  logic [AW-1:0] host_base_addr = '0;
  logic [AW:0]   host_len = '0;
  logic          host_abort = 1'b0;
  logic          host_halt = 1'b0;
  logic          host_valid = 1'b0;
  logic [DW-1:0] host_data = '0;
  logic          host_ready;
  logic          write_to_imem;
  logic [AW-1:0] addr_imem_host;
  logic [DW-1:0] imem_data;
  logic          core_rst;
  logic          run;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_written;

  int tests = 0;
  int fails = 0;

  imem_load_ctrl #(.AW(AW), .DW(DW), .FLUSH_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .host_start(host_start), .host_base_addr(host_base_addr), .host_len(host_len),
    .host_abort(host_abort), .host_halt(host_halt),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .write_to_imem(write_to_imem), .addr_imem_host(addr_imem_host), .imem_data(imem_data),
    .core_rst(core_rst), .run(run), .busy(busy), .done(done), .err(err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [AW:0] len);
    host_base_addr = base;
    host_len       = len;
    host_start     = 1'b1;
    step();
    host_start     = 1'b0;
  endtask

  // Call on the cycle carrying the final write; ends on the first RUN cycle.
  task automatic flush_to_run(input string tag);
    host_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_flush_busy"}, busy, 1);
      chk({tag, "_flush_corerst"}, core_rst, 1);
    end
    step();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_run"}, run, 1);
    chk({tag, "_corerst0"}, core_rst, 0);
  endtask

  task automatic halt();
    host_halt = 1'b1;
    step();
    host_halt = 1'b0;
    chk("halt_run", run, 0);
    chk("halt_corerst", core_rst, 1);
    chk("halt_busy", busy, 0);
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_corerst", core_rst, 1);
    chk("rst_run", run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", host_ready, 0);
    chk("rst_wr", write_to_imem, 0);
    chk("rst_addr", addr_imem_host, 0);
    chk("rst_data", imem_data, 0);
    chk("rst_ww", words_written, 0);
    rst = 1'b0;
    step();
    chk("idle_corerst", core_rst, 1);

    // Normal load: base 0x010, three words back to back
    start(9'h010, 10'd3);
    chk("n_busy", busy, 1);
    chk("n_ready", host_ready, 1);
    chk("n_wr0", write_to_imem, 0);
    host_valid = 1'b1;
    host_data  = 32'hAAAA_0001;
    step();
    chk("n_wrA", write_to_imem, 1);
    chk("n_addrA", addr_imem_host, 9'h010);
    chk("n_dataA", imem_data, 32'hAAAA_0001);
    chk("n_wwA", words_written, 1);
    host_data = 32'hBBBB_0002;
    step();
    chk("n_wrB", write_to_imem, 1);
    chk("n_addrB", addr_imem_host, 9'h011);
    chk("n_dataB", imem_data, 32'hBBBB_0002);
    host_data = 32'hCCCC_0003;
    step();
    chk("n_wrC", write_to_imem, 1);
    chk("n_addrC", addr_imem_host, 9'h012);
    chk("n_dataC", imem_data, 32'hCCCC_0003);
    chk("n_wwC", words_written, 3);
    chk("n_ready_flush", host_ready, 0);
    host_valid = 1'b0;
    step();
    chk("n_wr_flush", write_to_imem, 0);
    step();
    step();
    chk("n_not_run_yet", run, 0);
    step();
    chk("n_done", done, 1);
    chk("n_run", run, 1);
    chk("n_corerst", core_rst, 0);
    chk("n_busy_run", busy, 0);
    chk("n_ww_run", words_written, 3);
    step();
    chk("n_done_pulse", done, 0);
    chk("n_run_hold", run, 1);
    // start ignored in RUN
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    chk("n_start_ignored", run, 1);

    // Halt and reload base 0, one word
    halt();
    start(9'h000, 10'd1);
    chk("r_err", err, 0);
    host_valid = 1'b1;
    host_data  = 32'h1234_5678;
    step();
    chk("r_wr", write_to_imem, 1);
    chk("r_addr", addr_imem_host, 0);
    chk("r_data", imem_data, 32'h1234_5678);
    flush_to_run("r");
    halt();

    // Backpressure: valid 1,0,0,1
    start(9'h020, 10'd2);
    host_valid = 1'b1;
    host_data  = 32'hE0E0_0000;
    step();
    chk("b_wr1", write_to_imem, 1);
    chk("b_addr1", addr_imem_host, 9'h020);
    host_valid = 1'b0;
    step();
    chk("b_gap1", write_to_imem, 0);
    step();
    chk("b_gap2", write_to_imem, 0);
    chk("b_ready_gap", host_ready, 1);
    host_valid = 1'b1;
    host_data  = 32'hF0F0_0001;
    step();
    chk("b_wr2", write_to_imem, 1);
    chk("b_addr2", addr_imem_host, 9'h021);
    chk("b_data2", imem_data, 32'hF0F0_0001);
    chk("b_ww", words_written, 2);
    flush_to_run("b");
    halt();

    // Range errors: len 0 and overflowing end
    start(9'h000, 10'd0);
    chk("z_err", err, 1);
    chk("z_busy", busy, 0);
    start(9'h1F0, 10'd32);
    chk("e_err", err, 1);
    chk("e_busy", busy, 0);
    chk("e_ready", host_ready, 0);
    host_valid = 1'b1;
    step();
    chk("e_wr", write_to_imem, 0);
    host_valid = 1'b0;
    // Exactly fits: ends at 0x1FF
    start(9'h1F0, 10'd16);
    chk("f_err_clr", err, 0);
    chk("f_busy", busy, 1);
    host_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_data = 32'h0000_0100 + 32'(i);
      step();
      chk("f_wr", write_to_imem, 1);
      chk("f_addr", addr_imem_host, 9'h1F0 + 9'(i));
    end
    chk("f_last_addr", addr_imem_host, 9'h1FF);
    chk("f_ww", words_written, 16);
    flush_to_run("f");
    halt();

    // Abort with the third handshake
    start(9'h040, 10'd8);
    host_valid = 1'b1;
    host_data  = 32'hA0;
    step();
    host_data = 32'hA1;
    step();
    chk("a_ww2", words_written, 2);
    host_data  = 32'hA2;
    host_abort = 1'b1;
    step();
    host_abort = 1'b0;
    host_valid = 1'b0;
    chk("a_wr", write_to_imem, 0);
    chk("a_err", err, 1);
    chk("a_ww", words_written, 2);
    chk("a_busy", busy, 0);
    chk("a_corerst", core_rst, 1);
    chk("a_ready", host_ready, 0);
    chk("a_addr_hold", addr_imem_host, 9'h041);

    // Async reset after one of four words
    start(9'h000, 10'd4);
    host_valid = 1'b1;
    host_data  = 32'hDEAD_BEEF;
    step();
    chk("ar_wr_before", write_to_imem, 1);
    rst = 1'b1;
    #1;
    chk("ar_wr", write_to_imem, 0);
    chk("ar_ww", words_written, 0);
    chk("ar_busy", busy, 0);
    chk("ar_corerst", core_rst, 1);
    chk("ar_ready", host_ready, 0);
    chk("ar_data", imem_data, 0);
    chk("ar_err", err, 0);
    host_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("ar_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
